// File: rtl/rvx_bus_delay_injector.sv
// Latency injector between the rvx_core data bus and the rvx_ram data port.
// Each response is held back by a fixed or LFSR-derived number of wait cycles.
module rvx_bus_delay_injector #(
   parameter logic [15:0] LFSR_SEED  = 16'hACE1,
   parameter int          DELAY_BITS = 3
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  delay_mode,
   input  logic [DELAY_BITS-1:0] fixed_delay,
   input  logic [31:0]           m_address,
   input  logic [31:0]           m_wdata,
   input  logic [3:0]            m_wstrobe,
   input  logic                  m_rrequest,
   input  logic                  m_wrequest,
   output logic [31:0]           m_rdata,
   output logic                  m_rresponse,
   output logic                  m_wresponse,
   output logic [31:0]           s_address,
   output logic [31:0]           s_wdata,
   output logic [3:0]            s_wstrobe,
   output logic                  s_rrequest,
   output logic                  s_wrequest,
   input  logic [31:0]           s_rdata,
   input  logic                  s_rresponse,
   input  logic                  s_wresponse,
   output logic                  protocol_error,
   output logic [31:0]           txn_count
);

   typedef enum logic [1:0] {IDLE, WAIT, HOLD, RESP} state_t;

   // An all-zero state would lock the LFSR up, so a zero seed is replaced.
   localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
   localparam logic [15:0] TAPS = 16'hB400;
   localparam logic [DELAY_BITS-1:0] CNT_ONE = {{(DELAY_BITS-1){1'b0}}, 1'b1};

   state_t                state, state_nxt;
   logic                  is_read;
   logic [DELAY_BITS-1:0] cnt;
   logic [DELAY_BITS-1:0] delay;
   logic [31:0]           rdata_q;
   logic [15:0]           lfsr;
   logic                  any_req, both_req, s_match, bypass;

   assign s_address = m_address;
   assign s_wdata   = m_wdata;
   assign s_wstrobe = m_wstrobe;

   assign any_req  = m_rrequest | m_wrequest;
   assign both_req = m_rrequest & m_wrequest;
   assign s_match  = is_read ? s_rresponse : s_wresponse;
   assign bypass   = (state == IDLE) && !enable;
   assign delay    = delay_mode ? fixed_delay : lfsr[DELAY_BITS-1:0];

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // enable is only looked at in IDLE, so a toggle never disturbs a transaction.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (enable && any_req) state_nxt = WAIT;
         WAIT:    if (s_match) state_nxt = HOLD;
         HOLD:    if (cnt == '0) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      s_rrequest  = 1'b0;
      s_wrequest  = 1'b0;
      m_rresponse = 1'b0;
      m_wresponse = 1'b0;
      m_rdata     = rdata_q;
      case (state)
         IDLE: begin
            // A simultaneous read+write keeps the read and drops the write.
            s_rrequest = m_rrequest;
            s_wrequest = m_wrequest & ~m_rrequest;
            if (!enable) begin
               m_rresponse = s_rresponse;
               m_wresponse = s_wresponse;
               m_rdata     = s_rdata;
            end
         end
         RESP: begin
            m_rresponse = is_read;
            m_wresponse = ~is_read;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         lfsr           <= SEED;
         is_read        <= 1'b0;
         cnt            <= '0;
         rdata_q        <= '0;
         protocol_error <= 1'b0;
         txn_count      <= '0;
      end else begin
         lfsr <= lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
         if (state == IDLE && any_req) is_read <= m_rrequest;
         if (state == WAIT && s_match) begin
            cnt <= delay;
            if (is_read) rdata_q <= s_rdata;
         end else if (state == HOLD && cnt != '0) begin
            cnt <= cnt - CNT_ONE;
         end
         // Bypass reads also refresh the holding register so m_rdata stays coherent.
         if (bypass && s_rresponse) rdata_q <= s_rdata;
         if (both_req || (any_req && state != IDLE)) protocol_error <= 1'b1;
         if (m_rresponse || m_wresponse) txn_count <= txn_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_rvx_bus_delay_injector.sv
// Scoreboard bench for rvx_bus_delay_injector with a behavioural RAM and LFSR reference.
module tb_rvx_bus_delay_injector;
   localparam int DB = 3;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          enable = 1'b1;
   logic          delay_mode = 1'b1;
   logic [DB-1:0] fixed_delay = '0;
   logic [31:0]   m_address = '0, m_wdata = '0;
   logic [3:0]    m_wstrobe = '0;
   logic          m_rrequest = 1'b0, m_wrequest = 1'b0;
   logic [31:0]   m_rdata;
   logic          m_rresponse, m_wresponse;
   logic [31:0]   s_address, s_wdata;
   logic [3:0]    s_wstrobe;
   logic          s_rrequest, s_wrequest;
   logic [31:0]   s_rdata = 32'h5A5A5A5A;
   logic          s_rresponse = 1'b0, s_wresponse = 1'b0;
   logic          protocol_error;
   logic [31:0]   txn_count;

   rvx_bus_delay_injector #(.LFSR_SEED(16'hACE1), .DELAY_BITS(DB)) dut (
      .clock(clock), .reset(reset), .enable(enable), .delay_mode(delay_mode),
      .fixed_delay(fixed_delay), .m_address(m_address), .m_wdata(m_wdata),
      .m_wstrobe(m_wstrobe), .m_rrequest(m_rrequest), .m_wrequest(m_wrequest),
      .m_rdata(m_rdata), .m_rresponse(m_rresponse), .m_wresponse(m_wresponse),
      .s_address(s_address), .s_wdata(s_wdata), .s_wstrobe(s_wstrobe),
      .s_rrequest(s_rrequest), .s_wrequest(s_wrequest), .s_rdata(s_rdata),
      .s_rresponse(s_rresponse), .s_wresponse(s_wresponse),
      .protocol_error(protocol_error), .txn_count(txn_count)
   );

   always #5 clock = ~clock;

   int n_chk = 0, n_err = 0;
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // Reference LFSR: 16-bit Galois, taps 0xB400, free-running from the seed.
   logic [15:0] lfsr_m;
   always @(posedge clock)
      if (reset) lfsr_m <= 16'hACE1;
      else       lfsr_m <= lfsr_m[0] ? ((lfsr_m >> 1) ^ 16'hB400) : (lfsr_m >> 1);

   // RAM: answers one cycle after a request; s_rdata is noise otherwise.
   logic [31:0] mem [logic [31:0]];
   logic        pend_v = 1'b0, pend_rd = 1'b0;
   logic [31:0] pend_data = '0;

   function automatic logic [31:0] ram_rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : (32'hDEAD0000 ^ a);
   endfunction

   always @(posedge clock) begin
      s_rresponse <= 1'b0;
      s_wresponse <= 1'b0;
      s_rdata     <= $urandom();
      if (pend_v) begin
         pend_v <= 1'b0;
         if (pend_rd) begin s_rresponse <= 1'b1; s_rdata <= pend_data; end
         else         s_wresponse <= 1'b1;
      end
      if (s_rrequest) begin
         pend_v <= 1'b1; pend_rd <= 1'b1; pend_data <= ram_rd(s_address);
      end else if (s_wrequest) begin
         logic [31:0] w;
         w = ram_rd(s_address);
         for (int b = 0; b < 4; b++) if (s_wstrobe[b]) w[b*8 +: 8] = s_wdata[b*8 +: 8];
         mem[s_address] = w;
         pend_v <= 1'b1; pend_rd <= 1'b0;
      end
   end

   typedef struct { logic rd; logic [31:0] data; } exp_t;
   exp_t sb[$];
   int   s_resp_cyc = 0, exp_lat = 0, n_resp = 0, last_lat = 0;

   always @(negedge clock) begin
      exp_t e;
      if (s_rresponse || s_wresponse) begin
         s_resp_cyc = cyc;
         exp_lat = !enable ? 0 : delay_mode ? 2 + int'(fixed_delay) : 2 + int'(lfsr_m[DB-1:0]);
      end
      if (m_rresponse || m_wresponse) begin
         n_resp++;
         last_lat = cyc - s_resp_cyc;
         chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("resp_kind", 32'(m_rresponse), 32'(e.rd));
            if (e.rd) chk("rdata", m_rdata, e.data);
            chk("latency", last_lat, exp_lat);
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic reset_dut();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      sb.delete();
   endtask

   task automatic do_read(input logic [31:0] a);
      exp_t e;
      e.rd = 1'b1; e.data = ram_rd(a);
      sb.push_back(e);
      m_address = a; m_rrequest = 1'b1;
      #1 chk("s_rreq_fwd", 32'(s_rrequest), 32'd1);
      tick();
      m_rrequest = 1'b0;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
      exp_t e;
      e.rd = 1'b0; e.data = '0;
      sb.push_back(e);
      m_address = a; m_wdata = d; m_wstrobe = st; m_wrequest = 1'b1;
      #1 chk("s_wreq_fwd", 32'(s_wrequest), 32'd1);
      tick();
      m_wrequest = 1'b0;
   endtask

   task automatic wait_resp(input string tag);
      int n0, k;
      n0 = n_resp; k = 0;
      while (n_resp == n0 && k < 60) begin @(posedge clock); k++; end
      #1;
      chk({tag, "_timeout"}, 32'(n_resp != n0), 32'd1);
      chk({tag, "_pulse"}, 32'(m_rresponse | m_wresponse), 32'd0);
   endtask

   task automatic wait_sresp(input string tag);
      int k;
      k = 0;
      while (!s_rresponse && k < 20) begin tick(); k++; end
      chk({tag, "_sresp"}, 32'(s_rresponse), 32'd1);
   endtask

   int lat1 [1000];
   int n0;

   initial begin
      mem[32'h100] = 32'h12345678;
      tick(); tick();
      reset = 1'b0;
      chk("rst_rresp", 32'(m_rresponse), 32'd0);
      chk("rst_wresp", 32'(m_wresponse), 32'd0);
      chk("rst_rdata", m_rdata, 32'd0);
      chk("rst_perr", 32'(protocol_error), 32'd0);
      chk("rst_txn", txn_count, 32'd0);

      // Transparent bypass
      enable = 1'b0;
      do_read(32'h100);
      wait_resp("t1");
      chk("t1_txn", txn_count, 32'd1);

      // Fixed zero delay, then data holds while the RAM bus is noisy
      enable = 1'b1; delay_mode = 1'b1; fixed_delay = 3'd0;
      do_read(32'h100);
      wait_resp("t2");
      repeat (3) tick();
      chk("t2_rdata_hold", m_rdata, 32'h12345678);
      chk("t2_txn", txn_count, 32'd2);

      // Fixed max delay write, strobed write, read-back
      reset_dut();
      fixed_delay = 3'd7;
      do_write(32'h1000, 32'hCAFEF00D, 4'hF);
      wait_resp("t3");
      chk("t3_mem", mem[32'h1000], 32'hCAFEF00D);
      chk("t3_txn", txn_count, 32'd1);
      do_write(32'h1000, 32'h11223344, 4'b0101);
      wait_resp("t3s");
      chk("t3_mem_strobe", mem[32'h1000], 32'hCA22F044);
      do_read(32'h1000);
      wait_resp("t3r");
      chk("t3_txn3", txn_count, 32'd3);

      // Request while busy is dropped and flagged; original still completes
      reset_dut();
      fixed_delay = 3'd5;
      chk("t5_perr_pre", 32'(protocol_error), 32'd0);
      do_read(32'h100);
      wait_sresp("t5");
      tick();
      m_address = 32'h200; m_rrequest = 1'b1;
      #1 chk("t5_no_fwd", 32'(s_rrequest), 32'd0);
      tick();
      m_rrequest = 1'b0;
      chk("t5_perr", 32'(protocol_error), 32'd1);
      wait_resp("t5");
      repeat (5) tick();
      chk("t5_perr_sticky", 32'(protocol_error), 32'd1);
      reset_dut();
      chk("t5_perr_clr", 32'(protocol_error), 32'd0);

      // Read and write in the same cycle: read wins, flag set
      begin
         exp_t e;
         e.rd = 1'b1; e.data = ram_rd(32'h100);
         sb.push_back(e);
      end
      m_address = 32'h100; m_rrequest = 1'b1; m_wrequest = 1'b1;
      #1;
      chk("both_rreq", 32'(s_rrequest), 32'd1);
      chk("both_wreq", 32'(s_wrequest), 32'd0);
      tick();
      m_rrequest = 1'b0; m_wrequest = 1'b0;
      wait_resp("both");
      chk("both_perr", 32'(protocol_error), 32'd1);

      // Reset while in HOLD discards the transaction
      reset_dut();
      fixed_delay = 3'd7;
      do_read(32'h100);
      wait_sresp("t6");
      tick(); tick();
      reset_dut();
      n0 = n_resp;
      repeat (15) tick();
      chk("t6_no_resp", n_resp - n0, 32'd0);
      chk("t6_txn", txn_count, 32'd0);
      do_read(32'h100);
      wait_resp("t6n");
      chk("t6_txn1", txn_count, 32'd1);

      // Random delays: range, count, and reproducibility after reset
      delay_mode = 1'b0;
      reset_dut();
      for (int i = 0; i < 1000; i++) begin
         do_read(32'(i * 4));
         wait_resp("t4a");
         lat1[i] = last_lat;
         chk("t4_range", 32'(last_lat >= 2 && last_lat <= 9), 32'd1);
      end
      chk("t4_txn", txn_count, 32'd1000);
      chk("t4_perr", 32'(protocol_error), 32'd0);
      reset_dut();
      for (int i = 0; i < 1000; i++) begin
         do_read(32'(i * 4));
         wait_resp("t4b");
         chk("t4_repeat", last_lat, lat1[i]);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
